// File: rtl/mfp_ahb_buzzer_seq.sv
// mfp_ahb_buzzer_seq: note sequencer for the buzzer.
// Software queues {note, duration_ms} entries in a small FIFO; on start the
// entries are played in order, each followed by a muted articulation gap.
// note_out feeds the buzzer's note-select input (0 = mute, 1..7 = do..xi).
module mfp_ahb_buzzer_seq #(
   parameter int TICK_DIV   = 50000,
   parameter int GAP_MS     = 20,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  wr_en,
   input  logic [14:0]           wr_data,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  flush,
   output logic [2:0]            note_out,
   output logic                  busy,
   output logic                  done,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic                  full,
   output logic                  ovf
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int TW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int GW    = (GAP_MS > 1) ? $clog2(GAP_MS + 1) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_MS);

   typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

   state_t                state, next_state;
   logic [14:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [14:0]           head;
   logic                  push, pop, fifo_empty;
   logic [TW-1:0]         tick_cnt;
   logic                  ms_tick, tick_run;
   logic [2:0]            note_reg;
   logic [11:0]           dur_cnt;
   logic [GW-1:0]         gap_cnt;
   logic                  done_next;
   logic [2:0]            note_next;

   assign head       = mem[rd_ptr];
   assign fifo_empty = (fifo_count == '0);
   assign full       = (fifo_count == {1'b1, {DEPTH_LOG2{1'b0}}});
   assign push       = wr_en && !full;
   assign pop        = (state == LOAD) && !fifo_empty;
   assign busy       = (state != IDLE);
   assign ms_tick    = ((state == PLAY) || (state == GAP)) && (tick_cnt == TICK_MAX);
   assign tick_run   = ((state == PLAY) || (state == GAP)) && (next_state == state);

   // FIFO storage; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // FIFO pointers, occupancy and sticky overflow; flush overrides push and pop
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         ovf        <= 1'b0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         ovf        <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         end
         if (push && !pop) begin
            fifo_count <= fifo_count + (DEPTH_LOG2+1)'(1);
         end else if (!push && pop) begin
            fifo_count <= fifo_count - (DEPTH_LOG2+1)'(1);
         end
         if (wr_en && full) begin
            ovf <= 1'b1;
         end
      end
   end

   // Next-state, done pulse and next buzzer code; stop overrides every state
   always_comb begin
      next_state = state;
      done_next  = 1'b0;
      note_next  = 3'd0;
      if (stop) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start && !fifo_empty) begin
                  next_state = LOAD;
               end
            end
            LOAD: begin
               if (fifo_empty) begin
                  next_state = IDLE;
                  done_next  = 1'b1;
               end else if (head[11:0] == 12'd0) begin
                  if (fifo_count > (DEPTH_LOG2+1)'(1)) begin
                     next_state = LOAD;
                  end else begin
                     next_state = IDLE;
                     done_next  = 1'b1;
                  end
               end else begin
                  next_state = PLAY;
               end
            end
            PLAY: begin
               if (ms_tick && (dur_cnt == 12'd1)) begin
                  if (GAP_MS > 0) begin
                     next_state = GAP;
                  end else if (!fifo_empty) begin
                     next_state = LOAD;
                  end else begin
                     next_state = IDLE;
                     done_next  = 1'b1;
                  end
               end
            end
            GAP: begin
               if (ms_tick && (gap_cnt == GW'(1))) begin
                  if (!fifo_empty) begin
                     next_state = LOAD;
                  end else begin
                     next_state = IDLE;
                     done_next  = 1'b1;
                  end
               end
            end
            default: next_state = IDLE;
         endcase
      end
      if (next_state == PLAY) begin
         note_next = (state == LOAD) ? head[14:12] : note_reg;
      end
   end

   // State register, registered outputs, ms prescaler and note/gap counters
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         done     <= 1'b0;
         note_out <= 3'd0;
         tick_cnt <= '0;
         note_reg <= 3'd0;
         dur_cnt  <= 12'd0;
         gap_cnt  <= '0;
      end else begin
         state    <= next_state;
         done     <= done_next;
         note_out <= note_next;
         tick_cnt <= (tick_run && !ms_tick) ? tick_cnt + TW'(1) : '0;
         if (stop) begin
            dur_cnt <= 12'd0;
            gap_cnt <= '0;
         end else begin
            if (pop) begin
               note_reg <= head[14:12];
               dur_cnt  <= head[11:0];
            end else if ((state == PLAY) && ms_tick) begin
               dur_cnt <= dur_cnt - 12'd1;
            end
            if ((state == PLAY) && (next_state == GAP)) begin
               gap_cnt <= GAP_LOAD;
            end else if ((state == GAP) && ms_tick) begin
               gap_cnt <= gap_cnt - GW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mfp_ahb_buzzer_seq.sv
// tb_mfp_ahb_buzzer_seq: self-checking bench for the buzzer note sequencer.
// Expected playback is derived from the queued entries as a cycle trace:
// one load cycle per entry, duration*TICK_DIV cycles of the note, then
// GAP_MS*TICK_DIV muted cycles, and finally a done pulse on return to idle.
module tb_mfp_ahb_buzzer_seq;

   localparam int TICK_DIV   = 4;
   localparam int GAP_MS     = 1;
   localparam int DEPTH_LOG2 = 3;

   typedef struct { logic [2:0] note; logic [11:0] dur; } entry_t;
   typedef struct { logic [2:0] note; logic busy; logic done; } exp_t;
   typedef struct { logic wr; logic [14:0] data; logic fl; int count; logic full; logic ovf; } vec_t;
   typedef struct { int at; logic [14:0] data; } inj_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        wr_en = 1'b0;
   logic [14:0] wr_data = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  note_out;
   logic        busy, done, full, ovf;
   logic [3:0]  fifo_count;

   int     checks = 0;
   int     errors = 0;
   entry_t plan[$];
   exp_t   expq[$];
   inj_t   inj[$];
   int     obs_count[$];
   vec_t   vecs[13];

   mfp_ahb_buzzer_seq #(
      .TICK_DIV(TICK_DIV), .GAP_MS(GAP_MS), .DEPTH_LOG2(DEPTH_LOG2)
   ) dut (
      .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
      .start(start), .stop(stop), .flush(flush), .note_out(note_out),
      .busy(busy), .done(done), .fifo_count(fifo_count), .full(full), .ovf(ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic w, input logic [14:0] d, input logic s,
                                input logic p, input logic f);
      wr_en = w; wr_data = d; start = s; stop = p; flush = f;
      @(posedge clk); #1;
      wr_en = 1'b0; start = 1'b0; stop = 1'b0; flush = 1'b0;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pushEntry(input logic [2:0] n, input logic [11:0] d);
      applyStimulus(1'b1, {n, d}, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic addPlan(input logic [2:0] n, input logic [11:0] d);
      entry_t e;
      e.note = n; e.dur = d;
      plan.push_back(e);
   endtask

   // Reference model: expected per-cycle trace starting with the cycle after start
   task automatic buildTrace();
      expq.delete();
      foreach (plan[i]) begin
         expq.push_back('{note: 3'd0, busy: 1'b1, done: 1'b0});
         if (plan[i].dur != 12'd0) begin
            repeat (int'(plan[i].dur) * TICK_DIV) expq.push_back('{note: plan[i].note, busy: 1'b1, done: 1'b0});
            repeat (GAP_MS * TICK_DIV) expq.push_back('{note: 3'd0, busy: 1'b1, done: 1'b0});
         end
      end
      expq.push_back('{note: 3'd0, busy: 1'b0, done: 1'b1});
      expq.push_back('{note: 3'd0, busy: 1'b0, done: 1'b0});
   endtask

   task automatic runPlayback(input string tag);
      buildTrace();
      obs_count.delete();
      for (int i = 0; i < expq.size(); i++) begin
         logic        w;
         logic [14:0] d;
         w = 1'b0; d = 15'd0;
         foreach (inj[j]) if (inj[j].at == i) begin w = 1'b1; d = inj[j].data; end
         applyStimulus(w, d, (i == 0), 1'b0, 1'b0);
         checkOutput($sformatf("%s note[%0d]", tag, i), int'(note_out), int'(expq[i].note));
         checkOutput($sformatf("%s busy[%0d]", tag, i), int'(busy), int'(expq[i].busy));
         checkOutput($sformatf("%s done[%0d]", tag, i), int'(done), int'(expq[i].done));
         obs_count.push_back(int'(fifo_count));
      end
      inj.delete();
      checkOutput({tag, " count_end"}, int'(fifo_count), 0);
   endtask

   initial begin
      // FIFO vectors: nine pushes (ninth dropped), flush, flush beating push, push, flush
      for (int i = 0; i < 9; i++) begin
         vecs[i] = '{wr: 1'b1, data: {3'(i % 8), 12'(i + 1)}, fl: 1'b0,
                     count: (i < 8) ? i + 1 : 8, full: (i >= 7), ovf: (i == 8)};
      end
      vecs[9]  = '{wr: 1'b0, data: 15'd0, fl: 1'b1, count: 0, full: 1'b0, ovf: 1'b0};
      vecs[10] = '{wr: 1'b1, data: 15'h1001, fl: 1'b1, count: 0, full: 1'b0, ovf: 1'b0};
      vecs[11] = '{wr: 1'b1, data: 15'h1001, fl: 1'b0, count: 1, full: 1'b0, ovf: 1'b0};
      vecs[12] = '{wr: 1'b0, data: 15'd0, fl: 1'b1, count: 0, full: 1'b0, ovf: 1'b0};

      // Reset values while reset is held
      #12;
      checkOutput("rst note_out", int'(note_out), 0);
      checkOutput("rst busy", int'(busy), 0);
      checkOutput("rst done", int'(done), 0);
      checkOutput("rst fifo_count", int'(fifo_count), 0);
      checkOutput("rst full", int'(full), 0);
      checkOutput("rst ovf", int'(ovf), 0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // Basic two-note playback
      $display("[TB] basic playback");
      plan.delete(); addPlan(3'd1, 12'd2); addPlan(3'd3, 12'd1);
      foreach (plan[i]) pushEntry(plan[i].note, plan[i].dur);
      checkOutput("basic count", int'(fifo_count), 2);
      runPlayback("basic");

      // Table-driven FIFO fill, overflow and flush
      $display("[TB] fifo vectors");
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].wr, vecs[i].data, 1'b0, 1'b0, vecs[i].fl);
         checkOutput($sformatf("vec%0d count", i), int'(fifo_count), vecs[i].count);
         checkOutput($sformatf("vec%0d full", i), int'(full), int'(vecs[i].full));
         checkOutput($sformatf("vec%0d ovf", i), int'(ovf), int'(vecs[i].ovf));
      end

      // Stop mid-note, ignored start while busy, start with empty FIFO
      $display("[TB] stop sequence");
      pushEntry(3'd5, 12'd3);
      applyStimulus(1'b0, 15'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("stop load busy", int'(busy), 1);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b0, 15'd0, (i == 3), 1'b0, 1'b0);
         checkOutput($sformatf("stop play note[%0d]", i), int'(note_out), 5);
      end
      applyStimulus(1'b0, 15'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("stop note_out", int'(note_out), 0);
      checkOutput("stop busy", int'(busy), 0);
      checkOutput("stop done", int'(done), 0);
      for (int i = 0; i < 3; i++) begin
         idleCycle();
         checkOutput($sformatf("stop after done[%0d]", i), int'(done), 0);
      end
      checkOutput("stop count", int'(fifo_count), 0);
      applyStimulus(1'b0, 15'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("empty start busy", int'(busy), 0);
      idleCycle();
      checkOutput("empty start busy2", int'(busy), 0);
      checkOutput("empty start done", int'(done), 0);
      pushEntry(3'd2, 12'd1);
      applyStimulus(1'b0, 15'd0, 1'b1, 1'b1, 1'b0);
      checkOutput("stop+start busy", int'(busy), 0);
      checkOutput("stop+start count", int'(fifo_count), 1);
      applyStimulus(1'b0, 15'd0, 1'b0, 1'b0, 1'b1);

      // Zero-duration entry is skipped
      $display("[TB] zero duration");
      plan.delete(); addPlan(3'd2, 12'd0); addPlan(3'd4, 12'd1);
      foreach (plan[i]) pushEntry(plan[i].note, plan[i].dur);
      runPlayback("zdur");

      // Entries pushed during playback, including push coincident with pop
      $display("[TB] push during playback");
      plan.delete(); addPlan(3'd6, 12'd1); addPlan(3'd7, 12'd1); addPlan(3'd1, 12'd1);
      pushEntry(3'd6, 12'd1);
      inj.push_back('{at: 2, data: {3'd7, 12'd1}});
      inj.push_back('{at: 10, data: {3'd1, 12'd1}});
      runPlayback("live");
      checkOutput("live count after pop", obs_count[1], 0);
      checkOutput("live count after push", obs_count[2], 1);
      checkOutput("live count in load", obs_count[9], 1);
      checkOutput("live count push+pop", obs_count[10], 1);

      // Randomized queues against the trace model
      for (int r = 0; r < 5; r++) begin
         int n;
         $display("[TB] random round %0d", r);
         n = $urandom_range(1, 8);
         plan.delete();
         for (int k = 0; k < n; k++) addPlan(3'($urandom_range(0, 7)), 12'($urandom_range(0, 3)));
         foreach (plan[i]) pushEntry(plan[i].note, plan[i].dur);
         checkOutput($sformatf("rand%0d count", r), int'(fifo_count), n);
         checkOutput($sformatf("rand%0d full", r), int'(full), (n == 8) ? 1 : 0);
         runPlayback($sformatf("rand%0d", r));
      end

      // Asynchronous reset in the middle of a note
      $display("[TB] reset mid-play");
      pushEntry(3'd3, 12'd2);
      pushEntry(3'd4, 12'd1);
      applyStimulus(1'b0, 15'd0, 1'b1, 1'b0, 1'b0);
      repeat (3) idleCycle();
      checkOutput("pre-reset note", int'(note_out), 3);
      #2 resetn = 1'b0;
      #1;
      checkOutput("async rst note", int'(note_out), 0);
      checkOutput("async rst busy", int'(busy), 0);
      checkOutput("async rst count", int'(fifo_count), 0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      checkOutput("post rst busy", int'(busy), 0);
      checkOutput("post rst count", int'(fifo_count), 0);
      plan.delete(); addPlan(3'd2, 12'd1);
      foreach (plan[i]) pushEntry(plan[i].note, plan[i].dur);
      runPlayback("postrst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
